spi_packet_decoder: RTL and testbench

- Registered, multi-channel successor to the two-byte SPI command decoder.
- Sits between the SPI byte receiver and the drawing/framebuffer logic. It assembles variable-length packets from a byte stream and keeps per-channel brush/colour configuration.
- Delivers position events through a one-deep valid/ready output register.
- Supports NUM_CH independent cursors, parametrised coordinate width, clamping, framing-error recovery and a drop counter.

---
 rtl/colors_pkg.sv | 14 +
 rtl/spi_packet_decoder_pkg.sv | 41 ++++
 rtl/spi_coord_assemble.sv | 50 +++++
 rtl/spi_packet_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_spi_packet_decoder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/colors_pkg.sv
// Shared colour constants for the drawing pipeline.
// Colours are 3-bit {red, green, blue} codes.
package colors_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/spi_packet_decoder_pkg.sv
// Shared types and header field layout for the SPI packet decoder.
//   pkt_type_e  : decoded header type (CONF, POS, ILLEGAL)
//   state_e     : packet assembly FSM states
//   HDR_* / CONF_* : bit positions inside header and CONF payload bytes
package spi_pkg;

  typedef enum logic [1:0] {
    PKT_CONF,
    PKT_POS,
    PKT_ILLEGAL
  } pkt_type_e;

  typedef enum logic [1:0] {
    IDLE,
    CONF_PAY,
    POS_X,
    POS_Y
  } state_e;

  localparam int HDR_TYPE_MSB = 7;
  localparam int HDR_TYPE_LSB = 6;
  localparam int HDR_CH_MSB   = 3;
  localparam int HDR_CH_LSB   = 0;

  localparam logic [1:0] TYPE_CONF = 2'b11;
  localparam logic [1:0] TYPE_POS  = 2'b10;

  localparam int CONF_BRUSH_BIT = 4;
  localparam int CONF_COLOR_MSB = 2;
  localparam int CONF_COLOR_LSB = 0;

  // Any header whose top bit is clear is illegal.
  function automatic pkt_type_e decode_type(input logic [7:0] hdr);
    case (hdr[HDR_TYPE_MSB:HDR_TYPE_LSB])
      TYPE_CONF: return PKT_CONF;
      TYPE_POS:  return PKT_POS;
      default:   return PKT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/spi_coord_assemble.sv
// Coordinate assembler: shifts in CB bytes MSB first, truncates the result
// to COORD_W bits and clamps it to MAX.
//   clk, reset_n : clock, async active-low reset
//   shift_en     : byte_in is shifted in at this clock edge
//   byte_in      : payload byte
//   coord        : clamped coordinate; while shift_en is high it already
//                  includes byte_in, so the caller can use the completed
//                  value in the same cycle the last byte arrives
module spi_coord_assemble #(
  parameter int COORD_W = 8,
  parameter int MAX     = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [COORD_W-1:0] coord
);

  localparam int CB = (COORD_W + 7) / 8;
  localparam int AW = CB * 8;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [AW-1:0] acc_view;

  // Exactly CB shifts fully replace the old contents, so no explicit clear
  // is needed between packets (aborted partial data gets shifted out).
  always_comb begin
    acc_next = (acc << 8) | AW'(byte_in);
    acc_view = shift_en ? acc_next : acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (shift_en) begin
      acc <= acc_next;
    end
  end

  function automatic logic [COORD_W-1:0] clamp(input logic [AW-1:0] v);
    logic [COORD_W-1:0] t;
    t = COORD_W'(v);
    return (t > COORD_W'(MAX)) ? COORD_W'(MAX) : t;
  endfunction

  assign coord = clamp(acc_view);

endmodule

// File: rtl/spi_packet_decoder.sv
// SPI packet decoder: assembles CONF/POS packets from a received byte
// stream, keeps per-channel brush/colour configuration and presents
// position events through a one-deep valid/ready register.
//   clk, reset_n     : clock, async active-low reset
//   cs_active        : SPI frame in progress
//   byte_valid/data  : received byte strobe and value
//   pos_valid/ready  : position event handshake
//   pos_ch/x/y       : event channel and clamped coordinates
//   cfg_update/cfg_ch: one-cycle config change pulse and its channel
//   brush, color     : per-channel configuration (colour i at [3i+2:3i])
//   pkt_err          : one-cycle pulse on framing/channel/header error
//   drop_count       : saturating count of events lost to backpressure
module spi_packet_decoder
  import spi_pkg::*;
#(
  parameter int         NUM_CH        = 2,
  parameter int         COORD_W       = 8,
  parameter int         X_MAX         = 159,
  parameter int         Y_MAX         = 119,
  parameter logic [2:0] DEFAULT_COLOR = colors_pkg::GREEN,
  localparam int        CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs_active,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic [CH_W-1:0]       pos_ch,
  output logic [COORD_W-1:0]    pos_x,
  output logic [COORD_W-1:0]    pos_y,
  output logic                  cfg_update,
  output logic [CH_W-1:0]       cfg_ch,
  output logic [NUM_CH-1:0]     brush,
  output logic [3*NUM_CH-1:0]   color,
  output logic                  pkt_err,
  output logic [7:0]            drop_count
);

  localparam int CB   = (COORD_W + 7) / 8;
  localparam int CNT_W = (CB > 1) ? $clog2(CB) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         ch_q, ch_d;

  logic               accept;
  logic               ch_ok;
  logic               last_byte;
  logic               err_d;
  logic               conf_done;
  logic               pos_done;
  logic               x_shift;
  logic               y_shift;
  logic [CH_W-1:0]    ch_idx;
  logic [COORD_W-1:0] x_coord;
  logic [COORD_W-1:0] y_coord;

  logic [NUM_CH-1:0][2:0] color_q;

  assign accept    = byte_valid && cs_active;
  assign ch_ok     = (int'(ch_q) < NUM_CH);
  assign ch_idx    = ch_q[CH_W-1:0];
  assign last_byte = (cnt_q == CNT_W'(CB - 1));
  assign color     = color_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  // A frame that ends mid-packet takes priority over any byte in the same
  // cycle (that byte is outside the frame anyway). Packets for channels
  // that don't exist are still consumed in full so the stream stays in
  // sync; the error is reported once, after the final payload byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    err_d     = 1'b0;
    conf_done = 1'b0;
    pos_done  = 1'b0;
    x_shift   = 1'b0;
    y_shift   = 1'b0;

    if (state_q != IDLE && !cs_active) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          ch_d  = byte_data[HDR_CH_MSB:HDR_CH_LSB];
          cnt_d = '0;
          case (decode_type(byte_data))
            PKT_CONF: state_d = CONF_PAY;
            PKT_POS:  state_d = POS_X;
            default:  err_d   = 1'b1;
          endcase
        end
        CONF_PAY: begin
          state_d = IDLE;
          if (ch_ok) conf_done = 1'b1;
          else       err_d     = 1'b1;
        end
        POS_X: begin
          x_shift = 1'b1;
          if (last_byte) begin
            cnt_d   = '0;
            state_d = POS_Y;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        POS_Y: begin
          y_shift = 1'b1;
          if (last_byte) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (ch_ok) pos_done = 1'b1;
            else       err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  spi_coord_assemble #(
    .COORD_W (COORD_W),
    .MAX     (X_MAX)
  ) u_x_asm (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (x_shift),
    .byte_in  (byte_data),
    .coord    (x_coord)
  );

  // y_coord already includes the final byte while y_shift is high, so the
  // event can be loaded on the edge that accepts that byte.
  spi_coord_assemble #(
    .COORD_W (COORD_W),
    .MAX     (Y_MAX)
  ) u_y_asm (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (y_shift),
    .byte_in  (byte_data),
    .coord    (y_coord)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_update <= 1'b0;
      cfg_ch     <= '0;
      brush      <= '0;
      pkt_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        color_q[i] <= DEFAULT_COLOR;
      end
    end else begin
      cfg_update <= conf_done;
      pkt_err    <= err_d;
      if (conf_done) begin
        brush[ch_idx]   <= byte_data[CONF_BRUSH_BIT];
        color_q[ch_idx] <= byte_data[CONF_COLOR_MSB:CONF_COLOR_LSB];
        cfg_ch          <= ch_idx;
      end
    end
  end

  // Loading is allowed whenever the slot is empty or being emptied this
  // cycle, which gives a seamless handoff. Otherwise the new event is lost
  // and counted; the held event is never overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_valid  <= 1'b0;
      pos_ch     <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      drop_count <= '0;
    end else begin
      if (pos_done && (!pos_valid || pos_ready)) begin
        pos_valid <= 1'b1;
        pos_ch    <= ch_idx;
        pos_x     <= x_coord;
        pos_y     <= y_coord;
      end else begin
        if (pos_done && drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
        if (pos_valid && pos_ready) begin
          pos_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_packet_decoder.sv
// Testbench for spi_packet_decoder: directed scenarios plus randomized
// packet streams, checked every cycle against a packet-level model.
module tb_spi_packet_decoder;

  localparam int NUM_CH  = 2;
  localparam int COORD_W = 10;
  localparam int X_MAX   = 639;
  localparam int Y_MAX   = 479;
  localparam int CB      = 2;
  localparam int CH_W    = 1;
  localparam int GREEN   = 3'b010;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                cs_active = 1'b0;
  logic                byte_valid = 1'b0;
  logic [7:0]          byte_data = 8'h00;
  logic                pos_ready = 1'b0;
  logic                pos_valid;
  logic [CH_W-1:0]     pos_ch;
  logic [COORD_W-1:0]  pos_x;
  logic [COORD_W-1:0]  pos_y;
  logic                cfg_update;
  logic [CH_W-1:0]     cfg_ch;
  logic [NUM_CH-1:0]   brush;
  logic [3*NUM_CH-1:0] color;
  logic                pkt_err;
  logic [7:0]          drop_count;

  int checks_total  = 0;
  int checks_passed = 0;

  // Model state
  logic [7:0] m_q[$];
  bit         m_valid = 0;
  int         m_ch = 0, m_x = 0, m_y = 0;
  int         m_drop = 0;
  int         m_brush[NUM_CH];
  int         m_color[NUM_CH];
  int         m_cfg_ch = 0;
  bit         m_err = 0, m_cfgu = 0;

  logic [7:0] tx_q[$];

  spi_packet_decoder #(
    .NUM_CH  (NUM_CH),
    .COORD_W (COORD_W),
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs_active  (cs_active),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .pos_ch     (pos_ch),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .cfg_update (cfg_update),
    .cfg_ch     (cfg_ch),
    .brush      (brush),
    .color      (color),
    .pkt_err    (pkt_err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  function automatic int clampCoord(input int v, input int mx);
    int t;
    t = v % (1 << COORD_W);
    return (t > mx) ? mx : t;
  endfunction

  // Packet-level model: collect the bytes of the current packet and act on
  // the whole packet once its length (known from the header) is reached.
  task automatic modelStep(input bit cs, input bit bv, input logic [7:0] d, input bit rdy);
    bit old_valid;
    bit loaded;
    int need;
    int ch;
    int x;
    int y;
    old_valid = m_valid;
    loaded    = 0;
    m_err     = 0;
    m_cfgu    = 0;
    if (m_q.size() > 0 && !cs) begin
      m_q.delete();
      m_err = 1;
    end else if (cs && bv) begin
      m_q.push_back(d);
      need = (m_q[0][7:6] == 2'b11) ? 1 : 2 * CB;
      if (m_q.size() == 1 && m_q[0][7] == 1'b0) begin
        m_err = 1;
        m_q.delete();
      end else if (m_q.size() == 1 + need) begin
        ch = int'(m_q[0][3:0]);
        if (ch >= NUM_CH) begin
          m_err = 1;
        end else if (need == 1) begin
          m_brush[ch] = int'(m_q[1][4]);
          m_color[ch] = int'(m_q[1][2:0]);
          m_cfgu      = 1;
          m_cfg_ch    = ch;
        end else begin
          x = 0;
          y = 0;
          for (int k = 1; k <= CB; k++) x = x * 256 + int'(m_q[k]);
          for (int k = CB + 1; k <= 2 * CB; k++) y = y * 256 + int'(m_q[k]);
          if (!old_valid || rdy) begin
            m_valid = 1;
            m_ch    = ch;
            m_x     = clampCoord(x, X_MAX);
            m_y     = clampCoord(y, Y_MAX);
            loaded  = 1;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
        m_q.delete();
      end
    end
    if (!loaded && old_valid && rdy) m_valid = 0;
  endtask

  task automatic compareAll();
    logic [31:0] exp_brush;
    logic [31:0] exp_color;
    exp_brush = '0;
    exp_color = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_brush = exp_brush | (32'(m_brush[i]) << i);
      exp_color = exp_color | (32'(m_color[i]) << (3 * i));
    end
    checkOutput("pos_valid",  32'(pos_valid),  32'(m_valid));
    checkOutput("pos_ch",     32'(pos_ch),     32'(m_ch));
    checkOutput("pos_x",      32'(pos_x),      32'(m_x));
    checkOutput("pos_y",      32'(pos_y),      32'(m_y));
    checkOutput("cfg_update", 32'(cfg_update), 32'(m_cfgu));
    checkOutput("cfg_ch",     32'(cfg_ch),     32'(m_cfg_ch));
    checkOutput("pkt_err",    32'(pkt_err),    32'(m_err));
    checkOutput("drop_count", 32'(drop_count), 32'(m_drop));
    checkOutput("brush",      32'(brush),      exp_brush);
    checkOutput("color",      32'(color),      exp_color);
  endtask

  task automatic applyStimulus(input bit cs, input bit bv, input logic [7:0] d, input bit rdy);
    cs_active  = cs;
    byte_valid = bv;
    byte_data  = d;
    pos_ready  = rdy;
    @(posedge clk);
    modelStep(cs, bv, d, rdy);
    #1;
    compareAll();
  endtask

  // rdy_mode: 0 = never ready, 1 = always ready, 2 = random,
  // 3 = ready only on the final byte. Sends the first nsend bytes of tx_q,
  // then ends the frame with one cs-low cycle.
  task automatic sendPacket(input int rdy_mode, input int nsend, input bit gaps);
    bit rdy;
    for (int i = 0; i < nsend; i++) begin
      case (rdy_mode)
        0:       rdy = 0;
        1:       rdy = 1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (i == nsend - 1);
      endcase
      if (gaps && $urandom_range(0, 5) == 0) applyStimulus(1, 0, 8'h00, rdy);
      applyStimulus(1, 1, tx_q[i], rdy);
    end
    case (rdy_mode)
      0:       rdy = 0;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1;
    endcase
    applyStimulus(0, 0, 8'h00, rdy);
    tx_q.delete();
  endtask

  task automatic randomPacket(output int nsend);
    int kind;
    logic [7:0] hdr;
    kind = $urandom_range(0, 9);
    hdr  = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 4) != 0) hdr[3:0] = 4'($urandom_range(0, NUM_CH - 1));
    if (kind == 0) begin
      hdr[7] = 1'b0;
      tx_q.push_back(hdr);
    end else if (kind <= 3) begin
      hdr[7:6] = 2'b11;
      tx_q.push_back(hdr);
      tx_q.push_back(8'($urandom_range(0, 255)));
    end else begin
      hdr[7:6] = 2'b10;
      tx_q.push_back(hdr);
      for (int k = 0; k < 2 * CB; k++) begin
        tx_q.push_back(8'($urandom_range(0, 255)));
      end
    end
    nsend = tx_q.size();
    if (nsend > 1 && $urandom_range(0, 9) == 0) nsend = $urandom_range(1, nsend - 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NUM_CH; i++) begin
      m_brush[i] = 0;
      m_color[i] = GREEN;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // CONF on ch1
    tx_q = '{8'hC1, 8'h15};
    sendPacket(1, 2, 0);

    // POS ch0 (x=300, y clamps to 479) held, then a second one dropped
    tx_q = '{8'h80, 8'h01, 8'h2C, 8'h03, 8'hFF};
    sendPacket(0, 5, 0);
    tx_q = '{8'h81, 8'h00, 8'h10, 8'h00, 8'h20};
    sendPacket(0, 5, 0);
    // Third completes in the cycle ready rises: handoff
    tx_q = '{8'h81, 8'h02, 8'h80, 8'h01, 8'h00};
    sendPacket(3, 5, 0);

    // Frame aborted mid-packet, followed by a valid CONF
    tx_q = '{8'h80, 8'h01};
    sendPacket(1, 2, 0);
    tx_q = '{8'hC0, 8'h12};
    sendPacket(1, 2, 0);

    // Illegal header, then a POS for a nonexistent channel
    tx_q = '{8'h3F};
    sendPacket(1, 1, 0);
    tx_q = '{8'h85, 8'h00, 8'h05, 8'h00, 8'h06};
    sendPacket(1, 5, 0);

    // Bytes outside a frame are ignored
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 8'($urandom_range(0, 255)), 1);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      tx_q = '{8'h80, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      sendPacket(0, 5, 0);
    end
    applyStimulus(0, 0, 8'h00, 1);

    // Randomized stream
    for (int p = 0; p < 400; p++) begin
      randomPacket(n);
      sendPacket(2, n, 1);
      if ($urandom_range(0, 7) == 0) applyStimulus(0, 1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
